// File: rtl/io_pkg.sv
// Shared I/O constants for the byte-wide operand loader, multiplier core and result serializer.
package io_pkg;

  localparam int unsigned DATA_W  = 33;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned NBYTES  = (DATA_W + BYTE_W - 1) / BYTE_W;
  localparam int unsigned SHREG_W = NBYTES * BYTE_W;
  localparam int unsigned CNT_W   = $clog2(NBYTES);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StDone = 2'd2
  } ser_state_e;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: registers the input and flags a 0->1 transition for one cycle.
module rise_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/result_serializer.sv
// Emits a product word on an 8-bit bus, LSB first, one byte per acknowledge rising edge.
module result_serializer
  import io_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] result_in,
  input  logic              result_valid,
  input  logic              ack,
  output logic [BYTE_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              done
);

  ser_state_e         state_q, state_d;
  logic [SHREG_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ack_rise;

  rise_detect u_ack_rise (
    .clk_i  (clk),
    .rst_i  (rst),
    .d_i    (ack),
    .rise_o (ack_rise)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (result_valid) begin
          shreg_d = SHREG_W'(result_in);
          cnt_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (ack_rise) begin
          if (cnt_q == CNT_W'(NBYTES - 1)) begin
            // Clear so data_out reads zero once the frame is over.
            shreg_d = '0;
            cnt_d   = '0;
            state_d = StDone;
          end else begin
            shreg_d = shreg_q >> BYTE_W;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // All outputs decode registered state only; ack never reaches them combinationally.
  assign data_out   = shreg_q[BYTE_W-1:0];
  assign data_valid = (state_q == StSend);
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);

endmodule

// File: tb/tb_result_serializer.sv
// Directed self-checking bench for result_serializer.
module tb_result_serializer;

  logic        clk;
  logic        rst;
  logic [32:0] result_in;
  logic        result_valid;
  logic        ack;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        busy;
  logic        done;

  int checks;
  int failures;

  result_serializer u_dut (
    .clk          (clk),
    .rst          (rst),
    .result_in    (result_in),
    .result_valid (result_valid),
    .ack          (ack),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [32:0] value);
    result_in    = value;
    result_valid = 1'b1;
    step();
    result_valid = 1'b0;
    check("load_busy", 64'(busy), 64'd1);
  endtask

  // exp_bytes holds the five expected bytes, byte 0 in the low octet.
  task automatic byte_ack(input int k, input logic [39:0] exp_bytes, input int hi, input int lo);
    logic [7:0] eb;
    eb = exp_bytes[8*k +: 8];
    check($sformatf("byte%0d", k), 64'(data_out), 64'(eb));
    check($sformatf("valid%0d", k), 64'(data_valid), 64'd1);
    check($sformatf("nodone%0d", k), 64'(done), 64'd0);
    ack = 1'b1;
    step();
    if (k == 4) begin
      check("done_pulse", 64'(done), 64'd1);
      check("done_valid", 64'(data_valid), 64'd0);
      check("done_busy", 64'(busy), 64'd1);
      step();
      check("idle_done", 64'(done), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
      ack = 1'b0;
      step();
    end else begin
      repeat (hi - 1) step();
      ack = 1'b0;
      repeat (lo) step();
    end
  endtask

  task automatic send_rest(input int start, input logic [39:0] exp_bytes, input int hi,
                           input int lo);
    for (int k = start; k < 5; k++) byte_ack(k, exp_bytes, hi, lo);
  endtask

  task automatic run_frame(input logic [32:0] value, input logic [39:0] exp_bytes, input int hi,
                           input int lo);
    load(value);
    send_rest(0, exp_bytes, hi, lo);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    result_in    = '0;
    result_valid = 1'b0;
    ack          = 1'b0;
    step();
    step();
    check("rst_data", 64'(data_out), 64'd0);
    check("rst_valid", 64'(data_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    step();

    // Basic frame: 2-cycle ack pulses, 5 cycles apart.
    run_frame(33'h1_2345_6789, {8'h01, 8'h23, 8'h45, 8'h67, 8'h89}, 2, 3);

    // Top-bit handling at minimum ack width.
    run_frame(33'h0_FFFF_FFFF, {8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 1, 1);
    run_frame(33'h1_0000_0000, {8'h01, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 1);

    // Long ack: 7 cycles high per byte.
    run_frame(33'h0_C3B2_A190, {8'h00, 8'hC3, 8'hB2, 8'hA1, 8'h90}, 7, 2);

    // Ack already high at load: byte 0 held until ack toggles.
    ack = 1'b1;
    step();
    step();
    load(33'h0_5544_3322);
    check("prehigh_b0", 64'(data_out), 64'h22);
    repeat (3) step();
    check("prehigh_hold", 64'(data_out), 64'h22);
    check("prehigh_valid", 64'(data_valid), 64'd1);
    ack = 1'b0;
    step();
    check("prehigh_low", 64'(data_out), 64'h22);
    send_rest(0, {8'h00, 8'h55, 8'h44, 8'h33, 8'h22}, 1, 1);

    // Reload while sending byte 2 is ignored.
    load(33'h1_2345_6789);
    byte_ack(0, {8'h01, 8'h23, 8'h45, 8'h67, 8'h89}, 1, 1);
    byte_ack(1, {8'h01, 8'h23, 8'h45, 8'h67, 8'h89}, 1, 1);
    result_in    = 33'h0_AAAA_AAAA;
    result_valid = 1'b1;
    step();
    result_valid = 1'b0;
    check("reload_b2", 64'(data_out), 64'h45);
    send_rest(2, {8'h01, 8'h23, 8'h45, 8'h67, 8'h89}, 1, 1);
    run_frame(33'h0_AAAA_AAAA, {8'h00, 8'hAA, 8'hAA, 8'hAA, 8'hAA}, 1, 1);

    // Mid-frame reset after byte 1 is acknowledged.
    load(33'h1_2345_6789);
    byte_ack(0, {8'h01, 8'h23, 8'h45, 8'h67, 8'h89}, 1, 1);
    byte_ack(1, {8'h01, 8'h23, 8'h45, 8'h67, 8'h89}, 1, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_data", 64'(data_out), 64'd0);
    check("mrst_valid", 64'(data_valid), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("mrst_nodone", 64'(done), 64'd0);
    end
    run_frame(33'h0_0000_00A5, {8'h00, 8'h00, 8'h00, 8'h00, 8'hA5}, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_serializer.md
Name: result_serializer

Overview:
Transmit-side counterpart of the byte-wise operand loader. Takes the multiplier's 33-bit product in parallel and emits it on an 8-bit bus, one byte at a time, least-significant byte first. Each byte is held stable until the consumer acknowledges it with a strobe. This uses the same multi-cycle strobe convention as the input side's `ctrl`. Sits between the serial multiplier core and the board/host output interface.

Parameters:
DATA_W, 33, width of product word to transmit
BYTE_W, 8, width of output bus
NBYTES, 5, bytes per frame = ceil(DATA_W/BYTE_W); derived, not overridden

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
result_in  input  DATA_W  product word; sampled only on accepted result_valid
result_valid  input  1  single-cycle load request from multiplier core
ack  input  1  consumer byte acknowledge; level may stay high for several cycles; only its rising edge counts
data_out  output  BYTE_W  current byte
data_valid  output  1  data_out holds a valid byte awaiting ack
busy  output  1  frame in progress (state != IDLE)
done  output  1  one-cycle pulse after the last byte is acknowledged

Behaviour:
- Reset: when rst=1 at a clk edge, go to state IDLE.
  - data_out=0, data_valid=0, busy=0, done=0.
  - Shift register=0, byte counter=0, ack_q=0.
  - Reset mid-frame abandons the frame with no done pulse.
- ack_q registers ack every cycle in all states. ack_rise = ack & ~ack_q.
- State IDLE:
  - result_valid=1 at edge N: shift register <= result_in zero-extended to NBYTES*BYTE_W (upper 7 bits 0).
  - Counter <= 0; state <= SEND.
  - At N+1: data_out = result_in[7:0], data_valid=1, busy=1.
- State SEND:
  - data_out = shreg[7:0], held constant until ack_rise.
  - ack_rise at edge M with counter < NBYTES-1: shreg shifts right by BYTE_W, counter increments. Next byte appears at M+1.
  - ack_rise at edge M with counter == NBYTES-1: state <= DONE. At M+1: data_valid=0, done=1, busy=1.
  - Level-high ack without a new rising edge never advances. A strobe held across 1.5–3 cycles advances exactly one byte.
  - ack already high when the frame loads: no edge is seen, so byte 0 is held until ack drops and rises again.
  - result_valid in SEND or DONE is ignored; no re-load, no corruption.
- State DONE: lasts exactly one cycle (done=1), then IDLE. done=0 and busy=0 at M+2.
- ack_rise in IDLE or DONE: no effect.
- Latency:
  - Load to first byte: 1 cycle.
  - Ack edge to next byte: 1 cycle.
  - A frame takes at least 1 + NBYTES*2 cycles with minimum ack pulse width.
- Byte k of the frame = result_in[8k+7:8k]. Byte 4 = {7'b0, result_in[32]}.
- Outputs are registered; no combinational path from ack to data_out.

Decomposition:
- Shared package (io_pkg) holds:
  - DATA_W and BYTE_W, also used by the loader and the core.
  - NBYTES derivation.
  - State encoding constants: IDLE=2'd0, SEND=2'd1, DONE=2'd2.
- One sub-module: rise_detect (1-bit register + AND-NOT). Reusable by the loader's ctrl path.
- Counter width: $clog2(NBYTES) = 3 bits.

Test Plan:
- Basic frame:
  - Stimulus: rst 2 cycles; result_in=33'h1_2345_6789, result_valid pulse; ack pulses of 2 cycles spaced 5 cycles apart.
  - Response: data_out sequence 89,67,45,23,01 with data_valid=1 throughout. done pulses 1 cycle after the 5th ack edge; busy drops next cycle.
- Top-bit handling:
  - Stimulus: result_in=33'h0_FFFF_FFFF.
  - Response: bytes FF,FF,FF,FF,00. Same stimulus with 33'h1_0000_0000 gives 00,00,00,00,01.
- Long ack:
  - Stimulus: ack held high 7 cycles per byte.
  - Response: exactly one advance per high period. Ack high before load keeps byte 0 until ack toggles low then high.
- Reload ignored:
  - Stimulus: result_valid with 33'h0_AAAA_AAAA while in SEND at byte 2 of frame 33'h1_2345_6789.
  - Response: remaining bytes 45,23,01 unchanged. A new load is accepted only after done and the return to IDLE.
- Mid-frame reset:
  - Stimulus: rst=1 for 1 cycle after byte 1 is acknowledged.
  - Response: next cycle data_out=00, data_valid=0, busy=0, no done pulse. A following frame 33'h0_0000_00A5 emits A5,00,00,00,00.
